// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count, threshold flags, sticky
// overflow/underflow errors and an optional first-word-fall-through read port.
module sync_fifo #(
    parameter int ADDR_WIDTH    = 5,
    parameter int DATA_WIDTH    = 8,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 2,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Wr_enable,
    input  logic                  Read_enable,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AF_C    = AFULL_THRESH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_C    = AEMPTY_THRESH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH + 1)'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0] count_q, count_d;
    logic                full_q, empty_q, afull_q, aempty_q;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;
    logic                rd_acc, wr_acc;

    // Handshake: Wr_enable/Read_enable are requests taken on the rising edge
    // only when accepted. A read needs !empty; a write needs !full or a read
    // accepted in the same cycle. A rejected request sets its sticky error flag.
    always_comb begin
        rd_acc      = Read_enable && !empty_q;
        wr_acc      = Wr_enable && (!full_q || rd_acc);
        wr_ptr_d    = wr_acc ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d    = rd_acc ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d     = wr_ptr_d - rd_ptr_d;
        overflow_d  = overflow_q  | (Wr_enable   && !wr_acc);
        underflow_d = underflow_q | (Read_enable && !rd_acc);
    end

    // Flags come from count_d so they are always coherent with count.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            afull_q     <= 1'b0;
            aempty_q    <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= (count_d == DEPTH_C);
            empty_q     <= (count_d == '0);
            afull_q     <= (count_d >= AF_C);
            aempty_q    <= (count_d <= AE_C);
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && wr_acc) begin
            mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= data_in;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
        end else begin : g_std
            logic [DATA_WIDTH-1:0] data_out_q;
            always_ff @(posedge clk) begin
                if (reset) begin
                    data_out_q <= '0;
                end else if (rd_acc) begin
                    data_out_q <= mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
                end
            end
            assign data_out = data_out_q;
        end
    endgenerate

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: a standard-mode and an FWFT instance share stimulus and
// are compared against a queue-based model of the FIFO.
module tb_sync_fifo;

    localparam int AW    = 3;
    localparam int DW    = 8;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] din = '0;

    logic [DW-1:0] dout, dout_f;
    logic          full, empty, afull, aempty, ovf, unf;
    logic          full_f, empty_f, afull_f, aempty_f, ovf_f, unf_f;
    logic [AW:0]   count, count_f;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_q[$];
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;
    logic [DW-1:0] m_dout = '0;

    sync_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FWFT(0),
                .AFULL_THRESH(6), .AEMPTY_THRESH(1)) dut (
        .clk(clk), .reset(reset), .Wr_enable(wr_en), .Read_enable(rd_en),
        .data_in(din), .data_out(dout), .full(full), .empty(empty),
        .almost_full(afull), .almost_empty(aempty), .count(count),
        .overflow(ovf), .underflow(unf)
    );

    sync_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FWFT(1),
                .AFULL_THRESH(6), .AEMPTY_THRESH(1)) dut_fwft (
        .clk(clk), .reset(reset), .Wr_enable(wr_en), .Read_enable(rd_en),
        .data_in(din), .data_out(dout_f), .full(full_f), .empty(empty_f),
        .almost_full(afull_f), .almost_empty(aempty_f), .count(count_f),
        .overflow(ovf_f), .underflow(unf_f)
    );

    always #5 clk = ~clk;

    // One clock of stimulus; the model advances with the edge, outputs are
    // then stable for inline checks.
    task automatic cyc(input logic r, input logic w, input logic rd, input logic [DW-1:0] d);
        logic rd_ok, wr_ok;
        @(negedge clk);
        reset = r; wr_en = w; rd_en = rd; din = d;
        @(posedge clk);
        if (r) begin
            q.delete();
            m_ovf = 1'b0; m_unf = 1'b0; m_dout = '0;
        end else begin
            rd_ok = rd && (q.size() != 0);
            wr_ok = w && ((q.size() < DEPTH) || rd_ok);
            if (w && !wr_ok) m_ovf = 1'b1;
            if (rd && !rd_ok) m_unf = 1'b1;
            if (rd_ok) m_dout = q.pop_front();
            if (wr_ok) q.push_back(d);
        end
        #1;
    endtask

    task automatic idle_inputs();
        @(negedge clk);
        reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = '0;
    endtask

    task automatic test_reset();
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        checks++;
        if ({count, empty, full, aempty, afull, ovf, unf} !== {4'd0, 6'b101000}) begin
            errors++;
            $display("FAIL reset_flags: got cnt=%0d e=%b f=%b ae=%b af=%b ov=%b un=%b, want cnt=0 e=1 f=0 ae=1 af=0 ov=0 un=0",
                     count, empty, full, aempty, afull, ovf, unf);
        end
        checks++;
        if (dout !== 8'h00) begin
            errors++; $display("FAIL reset_dout: got %h want 00", dout);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 8'(i));
            checks++;
            if (count !== 4'(i)) begin
                errors++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i);
            end
            checks++;
            if ({aempty, afull, full, empty} !== {(i <= 1), (i >= 6), (i == 8), 1'b0}) begin
                errors++;
                $display("FAIL fill_flags[%0d]: got ae=%b af=%b f=%b e=%b", i, aempty, afull, full, empty);
            end
            checks++;
            if (dout_f !== 8'h01) begin
                errors++; $display("FAIL fill_fwft_head[%0d]: got %h want 01", i, dout_f);
            end
        end
        cyc(1'b0, 1'b1, 1'b0, 8'hFF);
        checks++;
        if ({ovf, full, count} !== {1'b1, 1'b1, 4'd8}) begin
            errors++; $display("FAIL fill_overflow: got ov=%b f=%b cnt=%0d want ov=1 f=1 cnt=8", ovf, full, count);
        end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 8'h00);
            checks++;
            if (dout !== 8'(i)) begin
                errors++; $display("FAIL drain_dout[%0d]: got %h want %h", i, dout, 8'(i));
            end
            checks++;
            if (count !== 4'(8 - i)) begin
                errors++; $display("FAIL drain_count[%0d]: got %0d want %0d", i, count, 8 - i);
            end
            if (i < 8) begin
                checks++;
                if (dout_f !== 8'(i + 1)) begin
                    errors++; $display("FAIL drain_fwft[%0d]: got %h want %h", i, dout_f, 8'(i + 1));
                end
            end
        end
        checks++;
        if ({empty, unf} !== 2'b10) begin
            errors++; $display("FAIL drain_empty: got e=%b un=%b want e=1 un=0", empty, unf);
        end
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        checks++;
        if ({unf, dout, count} !== {1'b1, 8'h08, 4'd0}) begin
            errors++; $display("FAIL drain_underflow: got un=%b dout=%h cnt=%0d want un=1 dout=08 cnt=0", unf, dout, count);
        end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] d, want;
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < 5; k++) begin
                d = 8'($urandom_range(0, 255));
                exp_q.push_back(d);
                cyc(1'b0, 1'b1, 1'b0, d);
            end
            for (int k = 0; k < 5; k++) begin
                cyc(1'b0, 1'b0, 1'b1, 8'h00);
                want = exp_q.pop_front();
                checks++;
                if (dout !== want) begin
                    errors++; $display("FAIL wrap_order[%0d.%0d]: got %h want %h", r, k, dout, want);
                end
            end
        end
        checks++;
        if ({count, empty} !== {4'd0, 1'b1}) begin
            errors++; $display("FAIL wrap_count: got cnt=%0d e=%b want cnt=0 e=1", count, empty);
        end
    endtask

    task automatic test_simul();
        logic [DW-1:0] first;
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        first = 8'($urandom_range(0, 255));
        cyc(1'b0, 1'b1, 1'b0, first);
        for (int i = 1; i < 8; i++) cyc(1'b0, 1'b1, 1'b0, 8'($urandom_range(0, 255)));
        cyc(1'b0, 1'b1, 1'b1, 8'h3C);
        checks++;
        if ({count, full, ovf, dout} !== {4'd8, 1'b1, 1'b0, first}) begin
            errors++;
            $display("FAIL simul_full: got cnt=%0d f=%b ov=%b dout=%h want cnt=8 f=1 ov=0 dout=%h", count, full, ovf, dout, first);
        end
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b1, 8'h00);
        checks++;
        if ({empty, unf} !== 2'b10) begin
            errors++; $display("FAIL simul_drained: got e=%b un=%b want e=1 un=0", empty, unf);
        end
        cyc(1'b0, 1'b1, 1'b1, 8'hC3);
        checks++;
        if ({count, empty, unf, ovf} !== {4'd1, 1'b0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL simul_empty: got cnt=%0d e=%b un=%b ov=%b want cnt=1 e=0 un=1 ov=0", count, empty, unf, ovf);
        end
        checks++;
        if (dout_f !== 8'hC3) begin
            errors++; $display("FAIL simul_empty_fwft: got %h want c3", dout_f);
        end
    endtask

    task automatic test_fwft();
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 1'b0, 8'hA5);
        checks++;
        if ({dout_f, empty_f} !== {8'hA5, 1'b0}) begin
            errors++; $display("FAIL fwft_first: got dout=%h e=%b want dout=a5 e=0", dout_f, empty_f);
        end
        cyc(1'b0, 1'b1, 1'b0, 8'h5A);
        checks++;
        if (dout_f !== 8'hA5) begin
            errors++; $display("FAIL fwft_head_held: got %h want a5", dout_f);
        end
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        checks++;
        if ({dout_f, count_f} !== {8'h5A, 4'd1}) begin
            errors++; $display("FAIL fwft_pop: got dout=%h cnt=%0d want dout=5a cnt=1", dout_f, count_f);
        end
    endtask

    task automatic test_midreset();
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1, 1'b0, 8'(8'h40 + i));
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 8'h00);
        checks++;
        if ({count, ovf} !== {4'd5, 1'b1}) begin
            errors++; $display("FAIL midreset_setup: got cnt=%0d ov=%b want cnt=5 ov=1", count, ovf);
        end
        cyc(1'b1, 1'b1, 1'b1, 8'h99);
        checks++;
        if ({count, empty, ovf, unf, dout} !== {4'd0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL midreset: got cnt=%0d e=%b ov=%b un=%b dout=%h want cnt=0 e=1 ov=0 un=0 dout=00",
                     count, empty, ovf, unf, dout);
        end
    endtask

    task automatic test_random();
        logic [5:0] want_flags;
        int wr_pct;
        for (int ph = 0; ph < 3; ph++) begin
            wr_pct = 70 - 20 * ph;
            for (int n = 0; n < 200; n++) begin
                cyc(($urandom_range(0, 149) == 0),
                    ($urandom_range(0, 99) < wr_pct),
                    ($urandom_range(0, 99) < 50),
                    8'($urandom_range(0, 255)));
                want_flags = {q.size() == DEPTH, q.size() == 0, q.size() >= 6,
                              q.size() <= 1, m_ovf, m_unf};
                checks++;
                if (count !== 4'(q.size())) begin
                    errors++; $display("FAIL rand_count[%0d.%0d]: got %0d want %0d", ph, n, count, q.size());
                end
                checks++;
                if ({full, empty, afull, aempty, ovf, unf} !== want_flags) begin
                    errors++;
                    $display("FAIL rand_flags[%0d.%0d]: got %b want %b", ph, n, {full, empty, afull, aempty, ovf, unf}, want_flags);
                end
                checks++;
                if ({count_f, full_f, empty_f, afull_f, aempty_f, ovf_f, unf_f} !== {4'(q.size()), want_flags}) begin
                    errors++; $display("FAIL rand_fwft_flags[%0d.%0d]: cnt=%0d flags mismatch model", ph, n, count_f);
                end
                checks++;
                if (dout !== m_dout) begin
                    errors++; $display("FAIL rand_dout[%0d.%0d]: got %h want %h", ph, n, dout, m_dout);
                end
                if (q.size() != 0) begin
                    checks++;
                    if (dout_f !== q[0]) begin
                        errors++; $display("FAIL rand_fwft_dout[%0d.%0d]: got %h want %h", ph, n, dout_f, q[0]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_simul();
        test_fwft();
        test_midreset();
        test_random();
        idle_inputs();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
